vram_arbiter: RTL and testbench
===============================

VRAM_ARBITER -- requirements
Module: vram_arbiter

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 11, meaning the video RAM address width (2048 bytes).
REQ-002 The block SHALL have parameter DATA_W, default 8, meaning the RAM data width.
REQ-003 The block SHALL have port clk, input, 1, the single clock (4 MHz pixel clock).
REQ-004 The block SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-005 The block SHALL have port vid_req, input, 1, video fetch strobe, one cycle per byte.
REQ-006 The block SHALL have port vid_addr, input, ADDR_W, video fetch address.
REQ-007 The block SHALL have port vid_data, output, DATA_W, fetched video byte.
REQ-008 The block SHALL have port vid_valid, output, 1, vid_data qualifier.
REQ-009 The block SHALL have port cpu_req, input, 1, CPU access level, held until cpu_ack.
REQ-010 The block SHALL have port cpu_we, input, 1, 1 = write, 0 = read.
REQ-011 The block SHALL have port cpu_addr, input, ADDR_W, CPU address.
REQ-012 The block SHALL have port cpu_wdata, input, DATA_W, CPU write data.
REQ-013 The block SHALL have port cpu_rdata, output, DATA_W, CPU read data, valid with cpu_ack.
REQ-014 The block SHALL have port cpu_ack, output, 1, one-cycle completion pulse.

Function
REQ-015 The block SHALL own one single-port synchronous RAM and grant its port to exactly one requester per cycle.
REQ-016 When vid_req=1 at edge t, the block SHALL read vid_addr at t, drive vid_data and assert vid_valid=1 for exactly cycle t+1: fixed latency 1, never stalled.
REQ-017 When vid_req=1 and cpu_req=1 at the same edge, the block SHALL serve video and keep the CPU request pending.
REQ-018 When cpu_req=1, vid_req=0 and the FSM is in IDLE, the block SHALL issue the CPU access and move to CPU_ACK.
REQ-019 A CPU read SHALL present RAM data on cpu_rdata with cpu_ack=1 one cycle after the grant edge.
REQ-020 A CPU write SHALL update RAM at the grant edge and pulse cpu_ack=1 one cycle later; cpu_rdata SHALL hold its previous value.
REQ-021 FSM states SHALL be IDLE and CPU_ACK.
REQ-022 In CPU_ACK, cpu_req SHALL be ignored (no double service); the FSM SHALL return to IDLE next cycle, and a video grant in that cycle SHALL still be honoured.
REQ-023 cpu_addr, cpu_we and cpu_wdata SHALL be sampled only at the grant edge; changes while pending or after grant SHALL have no effect.
REQ-024 Consecutive vid_req cycles SHALL each be served and SHALL starve the CPU for their duration; no timeout is applied.
REQ-025 A CPU write followed by a video read of the same address at the next edge SHALL return the new data.

Reset
REQ-026 While reset_n=0: FSM=IDLE, vid_valid=0, cpu_ack=0, vid_data=0, cpu_rdata=0; RAM write enable SHALL be forced 0; RAM contents SHALL NOT be cleared.
REQ-027 A reset asserted mid-access SHALL drop the pending or granted CPU access without cpu_ack; the CPU SHALL re-request after reset.

Configuration
REQ-028 With VRAM_ARBITER_STATS_EN defined, the block SHALL add output stall_count[15:0], reset 0; it SHALL increment, saturating at 16'hFFFF, on every cycle in which cpu_req=1, the FSM is in IDLE, and the CPU is not granted.
REQ-029 Without VRAM_ARBITER_STATS_EN, stall_count and its logic SHALL be absent.

Structure
REQ-030 ADDR_W, DATA_W and the FSM state encoding SHALL live in shared package vram_pkg.
REQ-031 The RAM SHALL be sub-module vram_sp: single port, synchronous read, 1-cycle latency, no reset.

Verification
REQ-032 The bench SHALL cover: CPU write 0x3C to 0x07F with vid_req idle -> cpu_ack 1 cycle after grant; a later CPU read of 0x07F -> cpu_rdata=0x3C with cpu_ack.
REQ-033 The bench SHALL cover: vid_req at addr 0x780 every 8 cycles, RAM holding 0xFE -> vid_valid and vid_data=0xFE exactly 1 cycle after each request.
REQ-034 The bench SHALL cover: cpu_req and vid_req raised on the same edge -> video served first; CPU granted the next cycle; cpu_ack 2 cycles after the request.
REQ-035 The bench SHALL cover: cpu_req held high for 1 cycle after cpu_ack -> exactly one RAM access and one ack.
REQ-036 The bench SHALL cover: reset_n pulled low 1 cycle after a CPU write grant -> no cpu_ack, all outputs 0, FSM in IDLE.
REQ-037 With VRAM_ARBITER_STATS_EN, the bench SHALL cover: 5 consecutive vid_req with cpu_req pending -> stall_count=5.

Source files
------------

// File: rtl/vram_pkg.sv
// Shared widths and arbiter FSM encoding for the video RAM arbiter.
// Imported by vram_sp and vram_arbiter.
package vram_pkg;

    localparam int VRAM_ADDR_W = 11;
    localparam int VRAM_DATA_W = 8;

    typedef enum logic {
        IDLE    = 1'b0,
        CPU_ACK = 1'b1
    } arbState_t;

endpackage

// File: rtl/vram_sp.sv
// Single-port synchronous RAM, read-first, 1-cycle read latency, no reset.
// Ports: clk, we, addr, wdata, rdata (registered).
import vram_pkg::*;

module vram_sp #(
    parameter int ADDR_W = VRAM_ADDR_W,
    parameter int DATA_W = VRAM_DATA_W
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        rdata <= mem[addr];
    end

endmodule

// File: rtl/vram_arbiter.sv
// Video/CPU arbiter for one single-port VRAM; video has fixed priority.
// Ports: clk, reset_n, vid_req/addr/data/valid, cpu_req/we/addr/wdata/rdata/ack;
// stall_count only when VRAM_ARBITER_STATS_EN is defined.
import vram_pkg::*;

module vram_arbiter #(
    parameter int ADDR_W = VRAM_ADDR_W,
    parameter int DATA_W = VRAM_DATA_W
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              vid_req,
    input  logic [ADDR_W-1:0] vid_addr,
    output logic [DATA_W-1:0] vid_data,
    output logic              vid_valid,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_ack
`ifdef VRAM_ARBITER_STATS_EN
    ,
    output logic [15:0]       stall_count
`endif
);

    arbState_t         state;
    logic              cpuGrant;
    logic              ramWe;
    logic [ADDR_W-1:0] ramAddr;
    logic [DATA_W-1:0] ramQ;
    logic              ackRead;
    logic [DATA_W-1:0] rdHold;

    // Video always wins; the CPU only gets an idle FSM and an idle video slot.
    assign cpuGrant = cpu_req & ~vid_req & (state == IDLE);
    assign ramWe    = cpuGrant & cpu_we & reset_n;
    assign ramAddr  = vid_req ? vid_addr : cpu_addr;

    vram_sp #(
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W)
    ) uRam (
        .clk  (clk),
        .we   (ramWe),
        .addr (ramAddr),
        .wdata(cpu_wdata),
        .rdata(ramQ)
    );

    // RAM output is shared; each side sees it only in its own result cycle.
    assign vid_data  = vid_valid ? ramQ : '0;
    assign cpu_rdata = ackRead ? ramQ : rdHold;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            vid_valid <= 1'b0;
            cpu_ack   <= 1'b0;
            ackRead   <= 1'b0;
            rdHold    <= '0;
        end else begin
            vid_valid <= vid_req;
            cpu_ack   <= cpuGrant;
            ackRead   <= cpuGrant & ~cpu_we;
            if (ackRead) begin
                rdHold <= ramQ;
            end
            unique case (state)
                IDLE: begin
                    if (cpuGrant) begin
                        state <= CPU_ACK;
                    end
                end
                CPU_ACK: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef VRAM_ARBITER_STATS_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stall_count <= '0;
        end else if (cpu_req && state == IDLE && !cpuGrant
                     && stall_count != 16'hFFFF) begin
            stall_count <= stall_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_vram_arbiter.sv
// Directed bench for vram_arbiter with a cycle-level behavioural model.
// Define VRAM_ARBITER_STATS_EN to also exercise stall_count.
module tb_vram_arbiter;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        vid_req;
    logic [10:0] vid_addr;
    logic [7:0]  vid_data;
    logic        vid_valid;
    logic        cpu_req;
    logic        cpu_we;
    logic [10:0] cpu_addr;
    logic [7:0]  cpu_wdata;
    logic [7:0]  cpu_rdata;
    logic        cpu_ack;
`ifdef VRAM_ARBITER_STATS_EN
    logic [15:0] stall_count;
`endif

    int checks = 0;
    int passed = 0;
    int ackCount = 0;
    bit cmpOn = 0;

    always #5 clk = ~clk;

    vram_arbiter dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .vid_req    (vid_req),
        .vid_addr   (vid_addr),
        .vid_data   (vid_data),
        .vid_valid  (vid_valid),
        .cpu_req    (cpu_req),
        .cpu_we     (cpu_we),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .cpu_rdata  (cpu_rdata),
        .cpu_ack    (cpu_ack)
`ifdef VRAM_ARBITER_STATS_EN
        ,
        .stall_count(stall_count)
`endif
    );

    // Behavioural model: memory image plus per-address "written" flag,
    // since RAM contents are undefined until the bench writes them.
    logic [7:0]  mMem [2048];
    bit          mKnown [2048];
    logic        eVal, eAck, busy, g;
    logic [7:0]  eVd, eRd;
    bit          vdK, rdK;
    logic [15:0] eStall;

    initial begin
        for (int i = 0; i < 2048; i++) mKnown[i] = 0;
    end

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            eVal = 0; eAck = 0; busy = 0; eStall = 0;
            eVd = 0; eRd = 0; vdK = 1; rdK = 1;
        end else begin
            g = cpu_req && !vid_req && !busy;
            if (cpu_req && !busy && !g && eStall != 16'hFFFF)
                eStall = eStall + 16'd1;
            eVal = vid_req;
            if (vid_req) begin
                eVd = mMem[vid_addr];
                vdK = mKnown[vid_addr];
            end
            eAck = g;
            if (g && !cpu_we) begin
                eRd = mMem[cpu_addr];
                rdK = mKnown[cpu_addr];
            end
            if (g && cpu_we) begin
                mMem[cpu_addr] = cpu_wdata;
                mKnown[cpu_addr] = 1;
            end
            busy = g;
        end
    end

    task automatic chk(input string nm, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp)
            $display("FAIL %s got=%0h expected=%0h at %0t", nm, got, exp, $time);
        else
            passed++;
    endtask

    always @(negedge clk) begin
        if (cpu_ack === 1'b1) ackCount++;
        if (cmpOn) begin
            chk("m_vid_valid", {31'b0, vid_valid}, {31'b0, eVal});
            chk("m_cpu_ack", {31'b0, cpu_ack}, {31'b0, eAck});
            if (!eVal)
                chk("m_vid_data_idle", {24'b0, vid_data}, 32'h0);
            else if (vdK)
                chk("m_vid_data", {24'b0, vid_data}, {24'b0, eVd});
            if (rdK)
                chk("m_cpu_rdata", {24'b0, cpu_rdata}, {24'b0, eRd});
`ifdef VRAM_ARBITER_STATS_EN
            chk("m_stall_count", {16'b0, stall_count}, {16'b0, eStall});
`endif
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic cpuSet(input logic r, input logic w,
                          input logic [10:0] a, input logic [7:0] d);
        cpu_req = r; cpu_we = w; cpu_addr = a; cpu_wdata = d;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int a0;
        reset_n = 0; vid_req = 0; vid_addr = 0;
        cpuSet(0, 0, 0, 0);
        tick(); tick();
        cmpOn = 1;
        chk("rst_vid_valid", {31'b0, vid_valid}, 0);
        chk("rst_cpu_ack", {31'b0, cpu_ack}, 0);
        chk("rst_vid_data", {24'b0, vid_data}, 0);
        chk("rst_cpu_rdata", {24'b0, cpu_rdata}, 0);
        reset_n = 1;
        tick();

        // CPU write 0x3C to 0x07F, req held through the ack cycle with
        // different data that must not be written.
        a0 = ackCount;
        cpuSet(1, 1, 11'h07F, 8'h3C);
        tick();
        chk("wr_ack", {31'b0, cpu_ack}, 1);
        chk("wr_rdata_held", {24'b0, cpu_rdata}, 0);
        cpu_wdata = 8'h55;
        tick();
        chk("wr_ack_once", {31'b0, cpu_ack}, 0);
        cpuSet(0, 0, 11'h07F, 8'h00);
        tick(); tick();
        chk("single_ack", ackCount - a0, 1);

        // CPU read back.
        cpuSet(1, 0, 11'h07F, 8'h00);
        tick();
        chk("rd_ack", {31'b0, cpu_ack}, 1);
        chk("rd_data", {24'b0, cpu_rdata}, 32'h3C);
        cpuSet(0, 0, 0, 0);
        tick();
        chk("rd_data_hold", {24'b0, cpu_rdata}, 32'h3C);

        // Fill 0x780 with 0xFE, then video fetch every 8 cycles.
        cpuSet(1, 1, 11'h780, 8'hFE);
        tick();
        cpuSet(0, 0, 0, 0);
        tick();
        for (int k = 0; k < 4; k++) begin
            vid_req = 1; vid_addr = 11'h780;
            tick();
            chk("vid_valid", {31'b0, vid_valid}, 1);
            chk("vid_data_fe", {24'b0, vid_data}, 32'hFE);
            vid_req = 0;
            tick();
            chk("vid_valid_drop", {31'b0, vid_valid}, 0);
            repeat (6) tick();
        end

        // Simultaneous requests: video first, CPU on the next edge.
        cpuSet(1, 0, 11'h07F, 8'h00);
        vid_req = 1; vid_addr = 11'h780;
        tick();
        chk("pri_vid", {24'b0, vid_data}, 32'hFE);
        chk("pri_no_ack", {31'b0, cpu_ack}, 0);
        vid_req = 0;
        tick();
        chk("pri_ack", {31'b0, cpu_ack}, 1);
        chk("pri_rdata", {24'b0, cpu_rdata}, 32'h3C);
        cpuSet(0, 0, 0, 0);
        tick();

        // Write then video read of same address during the ack cycle.
        cpuSet(1, 1, 11'h100, 8'hA5);
        tick();
        cpuSet(0, 0, 0, 0);
        vid_req = 1; vid_addr = 11'h100;
        tick();
        chk("wr_then_vid", {24'b0, vid_data}, 32'hA5);
        vid_req = 0;
        tick();

        // Reset during the ack cycle of a write.
        cpuSet(1, 1, 11'h200, 8'h77);
        tick();
        reset_n = 0;
        #1;
        chk("mid_rst_ack", {31'b0, cpu_ack}, 0);
        chk("mid_rst_vv", {31'b0, vid_valid}, 0);
        chk("mid_rst_vd", {24'b0, vid_data}, 0);
        chk("mid_rst_rd", {24'b0, cpu_rdata}, 0);
        cpuSet(0, 0, 0, 0);
        tick(); tick();
        reset_n = 1;
        tick();
        cpuSet(1, 0, 11'h200, 8'h00);
        tick();
        chk("post_rst_ack", {31'b0, cpu_ack}, 1);
        chk("post_rst_rd", {24'b0, cpu_rdata}, 32'h77);
        cpuSet(0, 0, 0, 0);
        tick();

        // Starvation: 5 video cycles with CPU pending, after a fresh reset.
        reset_n = 0;
        tick();
        reset_n = 1;
        tick();
`ifdef VRAM_ARBITER_STATS_EN
        chk("stall_rst", {16'b0, stall_count}, 0);
`endif
        cpuSet(1, 0, 11'h07F, 8'h00);
        vid_req = 1; vid_addr = 11'h780;
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("starve_no_ack", {31'b0, cpu_ack}, 0);
            chk("starve_vid", {24'b0, vid_data}, 32'hFE);
        end
`ifdef VRAM_ARBITER_STATS_EN
        chk("stall_five", {16'b0, stall_count}, 5);
`endif
        vid_req = 0;
        tick();
        chk("starve_ack", {31'b0, cpu_ack}, 1);
        chk("starve_rdata", {24'b0, cpu_rdata}, 32'h3C);
        cpuSet(0, 0, 0, 0);
        tick();
`ifdef VRAM_ARBITER_STATS_EN
        chk("stall_hold", {16'b0, stall_count}, 5);
`endif
        tick();
        cmpOn = 0;
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
